// File: rtl/keylock_seq_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the CLE204 key-lock sequencer.
// Optional feature macro: KEYSEQ_PARITY_EN (adds an odd-parity bit to the serial read).
package keylock_pkg;

   localparam int SEQ_LEN       = 4;
   localparam int DATA_BITS     = 8;
   localparam int STROBE_CYCLES = 2;
   localparam int GAP_CYCLES    = 1;

`ifdef KEYSEQ_PARITY_EN
   localparam int RD_BITS = DATA_BITS + 1;
`else
   localparam int RD_BITS = DATA_BITS;
`endif

   localparam int STEP_W = $clog2((SEQ_LEN > DATA_BITS + 1) ? SEQ_LEN : DATA_BITS + 1);
   localparam int PIDX_W = $clog2(SEQ_LEN);
   localparam int DIDX_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_UNLOCK,
      ST_READ,
      ST_RELOCK,
      ST_RESP
   } state_t;

   localparam logic [3:0] KEY_PATTERN [2][SEQ_LEN] = '{
      '{4'h3, 4'hA, 4'h5, 4'hC},
      '{4'h6, 4'h9, 4'h1, 4'hE}
   };
   localparam logic [3:0] KEY_READ_NIB = 4'h7;
   localparam logic [3:0] RELOCK_NIB   = 4'hF;

   function automatic logic [3:0] key_nib(input logic id, input logic [PIDX_W-1:0] idx);
      return KEY_PATTERN[id][idx];
   endfunction

   function automatic logic odd_par(input logic [DATA_BITS-1:0] d);
      return ~(^d);
   endfunction

   function automatic int rsp_latency();
      return (SEQ_LEN + RD_BITS + 1) * (STROBE_CYCLES + GAP_CYCLES) + 1;
   endfunction

endpackage

// File: rtl/keylock_seq_ctrl_if.sv
// Request/response handshake bundle between the bus master mux and keylock_seq_ctrl.
interface keylock_seq_ctrl_if;
   import keylock_pkg::*;

   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 rsp_id;
   logic [DATA_BITS-1:0] rsp_data;
   logic                 rsp_err;

   modport master (
      output req_valid, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

endinterface

// File: rtl/keylock_seq_ctrl_bus_access.sv
// One GAL window access: sser_n low for STROBE_CYCLES, then high for GAP_CYCLES.
// A start during the final gap clock chains the next access back-to-back.
module keylock_bus_access #(
   parameter int STROBE_CYCLES = 2,
   parameter int GAP_CYCLES    = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   output logic o_sser_n,
   output logic o_busy,
   output logic o_sample_now,
   output logic o_done
);

   localparam int CNT_W = $clog2(((STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES) + 1);
   localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   logic             r_busy;
   logic             r_in_gap;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sser_n;

   assign o_sample_now = r_busy && !r_in_gap && (r_cnt == STROBE_LAST);
   assign o_done       = r_busy &&  r_in_gap && (r_cnt == GAP_LAST);
   assign o_busy       = r_busy;
   assign o_sser_n     = r_sser_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_in_gap <= 1'b0;
         r_cnt    <= '0;
         r_sser_n <= 1'b1;
      end else if (i_start && (!r_busy || o_done)) begin
         r_busy   <= 1'b1;
         r_in_gap <= 1'b0;
         r_cnt    <= '0;
         r_sser_n <= 1'b0;
      end else if (r_busy) begin
         if (!r_in_gap) begin
            if (r_cnt == STROBE_LAST) begin
               r_in_gap <= 1'b1;
               r_cnt    <= '0;
               r_sser_n <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            if (r_cnt == GAP_LAST) begin
               r_busy   <= 1'b0;
               r_in_gap <= 1'b0;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/keylock_seq_ctrl.sv
// Key-lock window sequencer: arbitrates two requesters, replays the unlock nibbles,
// reads the serial word from SDRD and relocks. Optional macro: KEYSEQ_PARITY_EN.
module keylock_seq_ctrl
   import keylock_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   keylock_seq_ctrl_if.slave   bus,
   output logic                sser_n,
   output logic [3:0]          ba,
   input  logic                sdrd
);

   typedef logic [STEP_W-1:0] step_t;
   localparam step_t SEQ_LAST = step_t'(SEQ_LEN - 1);
   localparam step_t RD_LAST  = step_t'(RD_BITS - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_start_req;
   logic                 w_start;
   logic                 w_busy;
   logic                 w_sample_now;
   logic                 w_done;
   logic                 w_grant;
   step_t                r_step;
   step_t                w_step_inc;
   logic                 r_last_grant;
   logic [1:0]           r_req_ready;
   logic                 r_rsp_valid;
   logic                 r_rsp_id;
   logic [DATA_BITS-1:0] r_rsp_data;
   logic                 r_rsp_err;
   logic [3:0]           r_ba;
   logic                 r_sdrd;

   assign w_grant    = (bus.req_valid == 2'b11) ? ~r_last_grant : bus.req_valid[1];
   assign w_step_inc = r_step + step_t'(1);
   assign w_start    = w_start_req && (!w_busy || w_done);

   keylock_bus_access #(
      .STROBE_CYCLES (STROBE_CYCLES),
      .GAP_CYCLES    (GAP_CYCLES)
   ) u_access (
      .clk          (clk),
      .rst          (rst),
      .i_start      (w_start),
      .o_sser_n     (sser_n),
      .o_busy       (w_busy),
      .o_sample_now (w_sample_now),
      .o_done       (w_done)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_req = 1'b0;
      case (r_state)
         ST_IDLE:   if (|bus.req_valid) w_state_nxt = ST_ARB;
         ST_ARB: begin
            w_start_req = 1'b1;
            w_state_nxt = ST_UNLOCK;
         end
         ST_UNLOCK: begin
            if (w_done) begin
               w_start_req = 1'b1;
               if (r_step == SEQ_LAST) w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (w_done) begin
               w_start_req = 1'b1;
               if (r_step == RD_LAST) w_state_nxt = ST_RELOCK;
            end
         end
         ST_RELOCK: if (w_done) w_state_nxt = ST_RESP;
         ST_RESP:   if (r_rsp_valid && bus.rsp_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // ba for the next access is loaded as the current strobe ends, so it is settled for the whole gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
         r_req_ready  <= 2'b00;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_ba         <= RELOCK_NIB;
         r_step       <= '0;
         r_sdrd       <= 1'b0;
      end else begin
         r_sdrd      <= sdrd;
         r_req_ready <= 2'b00;
         case (r_state)
            ST_IDLE: begin
               if (|bus.req_valid) begin
                  r_req_ready  <= w_grant ? 2'b10 : 2'b01;
                  r_rsp_id     <= w_grant;
                  r_last_grant <= w_grant;
                  r_ba         <= key_nib(w_grant, '0);
                  r_rsp_data   <= '0;
                  r_rsp_err    <= 1'b0;
                  r_step       <= '0;
               end
            end
            ST_UNLOCK: begin
               if (w_sample_now)
                  r_ba <= (r_step == SEQ_LAST) ? KEY_READ_NIB : key_nib(r_rsp_id, w_step_inc[PIDX_W-1:0]);
               if (w_done) r_step <= (r_step == SEQ_LAST) ? '0 : w_step_inc;
            end
            ST_READ: begin
               if (w_sample_now) begin
                  if (r_step < step_t'(DATA_BITS))
                     r_rsp_data[r_step[DIDX_W-1:0]] <= r_sdrd;
`ifdef KEYSEQ_PARITY_EN
                  else
                     r_rsp_err <= (r_sdrd != odd_par(r_rsp_data));
`endif
                  r_ba <= (r_step == RD_LAST) ? RELOCK_NIB : KEY_READ_NIB;
               end
               if (w_done) r_step <= (r_step == RD_LAST) ? '0 : w_step_inc;
            end
            ST_RELOCK: if (w_done) r_rsp_valid <= 1'b1;
            ST_RESP:   if (r_rsp_valid && bus.rsp_ready) r_rsp_valid <= 1'b0;
            default:   r_rsp_valid <= 1'b0;
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_err   = r_rsp_err;
   assign ba            = r_ba;

endmodule
